pipelined_carry_select_subtractor: RTL
======================================

Name: pipelined_carry_select_subtractor

Overview:
- 16-bit subtractor computing diff = a - b - bin. It is the subtract-direction counterpart to the team's 16-bit carry-select adder.
- Built as a 4-stage pipeline. Each stage resolves one 4-bit slice, LSB slice first, using carry-select: both carry-in variants are precomputed and a mux selects on the registered carry from the previous stage.
- Has valid/ready handshakes on input and output. It sits in the datapath wherever a registered, back-pressurable subtract with flags is needed.

Parameters:
- WIDTH, 16, operand width. Fixed at 16; other values are unsupported.
- SLICE, 4, bits resolved per stage. Fixed at 4, which gives 4 stages.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset (sampled on rising edge of clk)
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- a  input  16  minuend
- b  input  16  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- diff  output  16  a - b - bin, modulo 2^16
- bout  output  1  unsigned borrow out: 1 when a < b + bin
- ovf  output  1  signed two's-complement overflow
- zero  output  1  diff == 16'h0000

Behaviour:
- Arithmetic: diff = a + ~b + ~bin, with internal carry c0 = ~bin. Per stage k (k = 0..3), on nibble k:
  - s0/c0k = a_k + ~b_k + 0
  - s1/c1k = a_k + ~b_k + 1
  - Select on the stage-(k-1) carry; stage 0 selects on ~bin.
- Flags:
  - bout = ~carry out of stage 3.
  - ovf = (a[15] != b[15]) && (diff[15] != a[15]), using the a[15] and b[15] captured with that transaction.
  - zero is registered in stage 3 from the full 16-bit result.
- Skew: unconsumed upper nibbles of a and ~b travel with the transaction. Completed lower diff nibbles are carried forward. a[15] and b[15] are carried to stage 3.
- Handshake and stall:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_valid and out_ready.
  - Input transfer occurs when in_valid && in_ready.
  - When adv = 1, every stage register (data and valid bit) shifts one stage; stage 0 loads new operands with valid = (in_valid && in_ready).
  - When adv = 0, all stage registers and outputs hold.
  - Bubbles are not collapsed.
- Latency: exactly 4 clk cycles from the input transfer edge to out_valid = 1, absent stalls. Throughput is 1 result per cycle.
- Output stability: diff, bout, ovf and zero are driven from stage-3 registers. They are stable while out_valid && !out_ready.
- Ordering: results emerge in acceptance order; no drop, no duplication.
- Reset (rst_n = 0 at a clk edge):
  - All stage valid bits clear; out_valid = 0.
  - diff = 0, bout = 0, ovf = 0, zero = 0.
  - All skew and carry registers clear.
  - in_ready is 1 on the first cycle after reset.
  - In-flight transactions are discarded and never emitted. in_valid during reset is ignored.
- Boundary conditions:
  - bin = 1 with a == b: diff = 16'hFFFF, bout = 1.
  - A borrow chain across all four slices must resolve correctly through the registered carries.
  - Simultaneous output accept and input accept in the same cycle is legal and loses nothing.
  - out_ready with out_valid = 0 has no effect.

Test Plan:
- a=16'h1234, b=16'h0234, bin=0, out_ready=1 -> 4 cycles later: diff=16'h1000, bout=0, ovf=0, zero=0.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0 (full borrow chain across all slices).
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1. Also a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, bout=1, ovf=1.
- a=16'h0010, b=16'h000F, bin=1 -> diff=16'h0000, zero=1, bout=0 (borrow crosses nibble 0 to nibble 1).
- Stall: issue 6 back-to-back ops (a = 16'h0100 + i, b = i, i = 0..5), then hold out_ready=0 for 3 cycles once the first result is valid.
  - in_ready must be 0 during the stall, and diff must hold its value.
  - Results must be in_order 16'h0100 x6 (each correct), with no loss or duplicates and 1/cycle after release.
- Reset mid-stream:
  - With 3 ops in flight, assert rst_n=0 for one cycle.
  - Next cycle: out_valid=0 and all outputs 0. None of the 3 ops is ever emitted.
  - A new op issued after reset returns correctly 4 cycles later.

Source files
------------

// File: rtl/pipelined_carry_select_subtractor_if.sv
// Operand/result handshake bundle for the pipelined carry-select subtractor.
// The master drives operands and out_ready; the slave (the subtractor) returns results.
interface pipelined_carry_select_subtractor_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/pipelined_carry_select_subtractor.sv
// 16-bit a - b - bin as a + ~b + ~bin, one 4-bit carry-select slice per pipeline stage.
// The whole pipeline advances together; a stalled output freezes every stage.
module pipelined_carry_select_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                              clk,
    input logic                              rst_n,
    pipelined_carry_select_subtractor_if.slave bus
);

    // Both carry-in variants are formed, the registered carry picks one.
    function automatic logic [4:0] csel_nibble(
        input logic [3:0] x,
        input logic [3:0] ny,
        input logic       cin
    );
        logic [4:0] sum_c0;
        logic [4:0] sum_c1;
        sum_c0 = {1'b0, x} + {1'b0, ny};
        sum_c1 = {1'b0, x} + {1'b0, ny} + 5'd1;
        return cin ? sum_c1 : sum_c0;
    endfunction

    logic w_adv;

    // Stage 0: captured operands, ~b and the initial carry ~bin.
    logic        r_s0_valid;
    logic [15:0] r_s0_a;
    logic [15:0] r_s0_nb;
    logic        r_s0_c;

    // Stages 1..3: unconsumed upper nibbles plus completed low diff bits.
    logic        r_s1_valid;
    logic [15:4] r_s1_a;
    logic [15:4] r_s1_nb;
    logic [3:0]  r_s1_d;
    logic        r_s1_c;

    logic        r_s2_valid;
    logic [15:8] r_s2_a;
    logic [15:8] r_s2_nb;
    logic [7:0]  r_s2_d;
    logic        r_s2_c;

    logic        r_s3_valid;
    logic [15:12] r_s3_a;
    logic [15:12] r_s3_nb;
    logic [11:0] r_s3_d;
    logic        r_s3_c;

    logic        r_out_valid;
    logic [15:0] r_diff;
    logic        r_bout;
    logic        r_ovf;
    logic        r_zero;

    logic [4:0]  w_n0;
    logic [4:0]  w_n1;
    logic [4:0]  w_n2;
    logic [4:0]  w_n3;
    logic [15:0] w_diff_full;
    logic        w_a15;
    logic        w_b15;

    assign w_adv = !r_out_valid || bus.out_ready;

    assign w_n0 = csel_nibble(r_s0_a[3:0],   r_s0_nb[3:0],   r_s0_c);
    assign w_n1 = csel_nibble(r_s1_a[7:4],   r_s1_nb[7:4],   r_s1_c);
    assign w_n2 = csel_nibble(r_s2_a[11:8],  r_s2_nb[11:8],  r_s2_c);
    assign w_n3 = csel_nibble(r_s3_a[15:12], r_s3_nb[15:12], r_s3_c);

    assign w_diff_full = {w_n3[3:0], r_s3_d};
    assign w_a15       = r_s3_a[15];
    assign w_b15       = ~r_s3_nb[15];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_valid  <= 1'b0;
            r_s0_a      <= '0;
            r_s0_nb     <= '0;
            r_s0_c      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_nb     <= '0;
            r_s1_d      <= '0;
            r_s1_c      <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_a      <= '0;
            r_s2_nb     <= '0;
            r_s2_d      <= '0;
            r_s2_c      <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_a      <= '0;
            r_s3_nb     <= '0;
            r_s3_d      <= '0;
            r_s3_c      <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            // in_ready equals w_adv here, so in_valid alone marks a transfer.
            r_s0_valid  <= bus.in_valid;
            r_s0_a      <= bus.a;
            r_s0_nb     <= ~bus.b;
            r_s0_c      <= ~bus.bin;

            r_s1_valid  <= r_s0_valid;
            r_s1_a      <= r_s0_a[15:4];
            r_s1_nb     <= r_s0_nb[15:4];
            r_s1_d      <= w_n0[3:0];
            r_s1_c      <= w_n0[4];

            r_s2_valid  <= r_s1_valid;
            r_s2_a      <= r_s1_a[15:8];
            r_s2_nb     <= r_s1_nb[15:8];
            r_s2_d      <= {w_n1[3:0], r_s1_d};
            r_s2_c      <= w_n1[4];

            r_s3_valid  <= r_s2_valid;
            r_s3_a      <= r_s2_a[15:12];
            r_s3_nb     <= r_s2_nb[15:12];
            r_s3_d      <= {w_n2[3:0], r_s2_d};
            r_s3_c      <= w_n2[4];

            r_out_valid <= r_s3_valid;
            r_diff      <= w_diff_full;
            r_bout      <= ~w_n3[4];
            r_ovf       <= (w_a15 != w_b15) && (w_n3[3] != w_a15);
            r_zero      <= (w_diff_full == 16'h0000);
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule
